// File: rtl/pam_pkg.sv
// Shared definitions for the pipelined array multiplier: stage-count helpers
// and the default-geometry stage record.
package pam_pkg;

   localparam int DEF_WIDTH_A        = 8;
   localparam int DEF_WIDTH_B        = 8;
   localparam int DEF_ROWS_PER_STAGE = 2;
   localparam int DEF_TAG_W          = 4;
   localparam int PW                 = DEF_WIDTH_A + DEF_WIDTH_B;

   function automatic int pam_stages(input int width_b, input int rows_per_stage);
      return (width_b + rows_per_stage - 1) / rows_per_stage;
   endfunction

   // Highest partial-product row owned by the stage whose first row is first_row.
   function automatic int pam_last_row(input int first_row, input int rows_per_stage,
                                       input int width_b);
      return (first_row + rows_per_stage < width_b) ? first_row + rows_per_stage - 1
                                                    : width_b - 1;
   endfunction

   typedef struct packed {
      logic [PW-1:0]          psum;
      logic [PW-1:0]          a;
      logic [DEF_WIDTH_B-1:0] b;
      logic                   sgn;
      logic [DEF_TAG_W-1:0]   tag;
      logic                   vld;
   } stage_rec_t;

endpackage

// File: rtl/pam_row_stage.sv
// Combinational accumulation of one stage's partial-product rows into the running sum.
// The MSB row of B is subtracted in signed mode, which with a sign-extended A gives an exact product.
module pam_row_stage
   import pam_pkg::*;
#(
   parameter int WIDTH_B        = 8,
   parameter int PROD_W         = 16,
   parameter int ROWS_PER_STAGE = 2,
   parameter int FIRST_ROW      = 0
) (
   input  logic [PROD_W-1:0]                  psum_i,
   input  logic [PROD_W-1:0]                  a_i,
   input  logic [pam_last_row(FIRST_ROW, ROWS_PER_STAGE, WIDTH_B)-FIRST_ROW:0] b_i,
   input  logic                               sgn_i,
   output logic [PROD_W-1:0]                  psum_o
);

   localparam int LAST_ROW = pam_last_row(FIRST_ROW, ROWS_PER_STAGE, WIDTH_B);
   localparam int NROWS    = LAST_ROW - FIRST_ROW + 1;

   logic [PROD_W-1:0] acc_d;

   always_comb begin
      acc_d = psum_i;
      for (int r = 0; r < NROWS; r++) begin
         if (b_i[r]) begin
            if (sgn_i && (FIRST_ROW + r == WIDTH_B - 1)) begin
               acc_d = acc_d - (a_i << (FIRST_ROW + r));
            end else begin
               acc_d = acc_d + (a_i << (FIRST_ROW + r));
            end
         end
      end
   end

   assign psum_o = acc_d;

endmodule

// File: rtl/pipelined_array_multiplier.sv
// Pipelined array multiplier: WIDTH_B partial-product rows spread over S registered stages.
// Single global stall (advance) holds every stage while the result waits on out_ready.
module pipelined_array_multiplier
   import pam_pkg::*;
#(
   parameter int WIDTH_A        = 8,
   parameter int WIDTH_B        = 8,
   parameter int ROWS_PER_STAGE = 2,
   parameter int TAG_W          = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH_A-1:0]         in_a,
   input  logic [WIDTH_B-1:0]         in_b,
   input  logic                       in_signed,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH_A+WIDTH_B-1:0] out_p,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       busy
);

   localparam int S      = pam_stages(WIDTH_B, ROWS_PER_STAGE);
   localparam int PROD_W = WIDTH_A + WIDTH_B;

   typedef struct packed {
      logic [PROD_W-1:0]  psum;
      logic [PROD_W-1:0]  a;
      logic [WIDTH_B-1:0] b;
      logic               sgn;
      logic [TAG_W-1:0]   tag;
      logic               vld;
   } stage_t;

   stage_t stage_q [S];
   stage_t stage_d [S];
   stage_t in_rec;
   logic   advance;

   assign advance  = !stage_q[S-1].vld || out_ready;
   assign in_ready = advance;

   // Operand fields are zeroed on bubbles so undefined inputs never enter the pipe.
   always_comb begin
      in_rec = '0;
      if (in_valid) begin
         in_rec.a   = in_signed ? {{WIDTH_B{in_a[WIDTH_A-1]}}, in_a}
                                : {{WIDTH_B{1'b0}}, in_a};
         in_rec.b   = in_b;
         in_rec.sgn = in_signed;
         in_rec.tag = in_tag;
         in_rec.vld = 1'b1;
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int FIRST = k * ROWS_PER_STAGE;
      localparam int LAST  = pam_last_row(FIRST, ROWS_PER_STAGE, WIDTH_B);

      stage_t            src;
      logic [PROD_W-1:0] psum_nxt;

      if (k == 0) begin : g_src_in
         assign src = in_rec;
      end else begin : g_src_q
         assign src = stage_q[k-1];
      end

      pam_row_stage #(
         .WIDTH_B       (WIDTH_B),
         .PROD_W        (PROD_W),
         .ROWS_PER_STAGE(ROWS_PER_STAGE),
         .FIRST_ROW     (FIRST)
      ) u_rows (
         .psum_i(src.psum),
         .a_i   (src.a),
         .b_i   (src.b[LAST:FIRST]),
         .sgn_i (src.sgn),
         .psum_o(psum_nxt)
      );

      assign stage_d[k] = '{psum: psum_nxt, a: src.a, b: src.b, sgn: src.sgn,
                            tag: src.tag, vld: src.vld};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < S; k++) begin
            stage_q[k] <= '0;
         end
      end else if (advance) begin
         for (int k = 0; k < S; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < S; k++) begin
         busy = busy | stage_q[k].vld;
      end
   end

   assign out_valid = stage_q[S-1].vld;
   assign out_p     = stage_q[S-1].psum;
   assign out_tag   = stage_q[S-1].tag;

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Directed bench for pipelined_array_multiplier: corners, bubbles, stall, reset and parameter sweep.
module tb_pipelined_array_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
   logic [7:0]  in_a, in_b;
   logic [3:0]  in_tag, out_tag;
   logic [15:0] out_p;

   int n_err = 0;
   int n_chk = 0;
   bit sweep_go = 1'b0;
   int sweep_done = 0;

   always #5 clk = ~clk;

   pipelined_array_multiplier dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag), .busy(busy)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input longint a, input longint b, input bit sgn,
                                           input int wa, input int wb);
      longint x = a;
      longint y = b;
      longint p;
      if (sgn && a[wa-1]) x = a - (longint'(1) << wa);
      if (sgn && b[wb-1]) y = b - (longint'(1) << wb);
      p = x * y;
      return p & ((longint'(1) << (wa + wb)) - 1);
   endfunction

   bit          v_vld [16];
   logic [7:0]  v_a   [16];
   logic [7:0]  v_b   [16];
   bit          v_s   [16];
   logic [3:0]  v_tag [16];
   logic [15:0] v_exp [16];

   task automatic set_vec(input int i, input bit vld, input logic [7:0] a, input logic [7:0] b,
                          input bit s, input logic [3:0] t, input logic [15:0] e);
      v_vld[i] = vld; v_a[i] = a; v_b[i] = b; v_s[i] = s; v_tag[i] = t; v_exp[i] = e;
   endtask

   // Slot j is driven before edge j; its result must be visible at negedge j+4.
   task automatic run_vec(input int n);
      for (int j = 0; j < n + 6; j++) begin
         @(negedge clk);
         if (j >= 4 && j - 4 < n) begin
            chk("vec_vld", 64'(out_valid), 64'(v_vld[j-4]));
            if (v_vld[j-4]) begin
               chk("vec_p", 64'(out_p), 64'(v_exp[j-4]));
               chk("vec_tag", 64'(out_tag), 64'(v_tag[j-4]));
            end
         end else begin
            chk("vec_idle", 64'(out_valid), 64'd0);
         end
         if (j < n && v_vld[j]) begin
            in_valid = 1'b1; in_a = v_a[j]; in_b = v_b[j]; in_signed = v_s[j]; in_tag = v_tag[j];
         end else begin
            in_valid = 1'b0; in_a = 'x; in_b = 'x;
         end
      end
   endtask

   initial begin
      longint bp_a [10];
      longint bp_b [10];
      bit     bp_s [10];
      int     sent = 0;
      int     got = 0;
      bit     prev_hold = 1'b0;
      logic [15:0] prev_p = '0;
      logic [3:0]  prev_tag = '0;

      in_valid = 1'b0; in_a = 'x; in_b = 'x; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_p", 64'(out_p), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      set_vec(0, 1, 8'h00, 8'hFF, 0, 4'd1, 16'h0000);
      set_vec(1, 1, 8'hFF, 8'hFF, 0, 4'd2, 16'hFE01);
      set_vec(2, 1, 8'h0F, 8'h10, 0, 4'd3, 16'h00F0);
      set_vec(3, 1, 8'h80, 8'h80, 1, 4'd4, 16'h4000);
      set_vec(4, 1, 8'hFF, 8'h01, 1, 4'd5, 16'hFFFF);
      set_vec(5, 1, 8'h7F, 8'h80, 1, 4'd6, 16'hC080);
      set_vec(6, 1, 8'h80, 8'h80, 0, 4'd7, 16'h4000);
      run_vec(7);

      set_vec(0, 1, 8'h03, 8'h05, 0, 4'd8,  16'h000F);
      set_vec(1, 0, 8'h00, 8'h00, 0, 4'd0,  16'h0000);
      set_vec(2, 1, 8'h12, 8'h10, 0, 4'd9,  16'h0120);
      set_vec(3, 1, 8'hFF, 8'h02, 0, 4'd10, 16'h01FE);
      set_vec(4, 0, 8'h00, 8'h00, 0, 4'd0,  16'h0000);
      set_vec(5, 1, 8'hFE, 8'h03, 1, 4'd11, 16'hFFFA);
      run_vec(6);

      // Full-rate stream with the consumer stalled for five cycles mid-stream.
      for (int i = 0; i < 10; i++) begin
         bp_a[i] = longint'($urandom_range(0, 255));
         bp_b[i] = longint'($urandom_range(0, 255));
         bp_s[i] = 1'($urandom_range(0, 1));
      end
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 6 && cyc < 11);
         if (sent < 10) begin
            in_valid = 1'b1; in_a = bp_a[sent][7:0]; in_b = bp_b[sent][7:0];
            in_signed = bp_s[sent]; in_tag = 4'(sent);
         end else begin
            in_valid = 1'b0; in_a = 'x; in_b = 'x;
         end
         #1;
         if (prev_hold) begin
            chk("bp_hold_p", 64'(out_p), 64'(prev_p));
            chk("bp_hold_tag", 64'(out_tag), 64'(prev_tag));
         end
         if (!out_ready) chk("bp_in_ready", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            chk("bp_p", 64'(out_p), ref_mul(bp_a[got], bp_b[got], bp_s[got], 8, 8));
            chk("bp_tag", 64'(out_tag), 64'(got));
            got++;
         end
         if (in_valid && in_ready) sent++;
         prev_hold = out_valid && !out_ready;
         prev_p = out_p;
         prev_tag = out_tag;
      end
      chk("bp_count", 64'(got), 64'd10);
      out_ready = 1'b1; in_valid = 1'b0; in_a = 'x; in_b = 'x;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk("bp_no_dup", 64'(out_valid), 64'd0);
      end

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = 8'(i + 1); in_b = 8'h11; in_signed = 1'b0; in_tag = 4'(i + 12);
      end
      @(negedge clk);
      in_valid = 1'b0; in_a = 'x; in_b = 'x;
      chk("inflight_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_now_valid", 64'(out_valid), 64'd0);
      chk("rst_now_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk("rst_stale", 64'(out_valid), 64'd0);
      end
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      sweep_go = 1'b1;
      for (int t = 0; t < 2000 && sweep_done < 3; t++) @(negedge clk);
      chk("sweep_done", 64'(sweep_done), 64'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int WA  = (g == 0) ? 4 : (g == 1) ? 16 : 5;
      localparam int WB  = (g == 0) ? 4 : (g == 1) ? 12 : 7;
      localparam int RPS = (g == 0) ? 4 : (g == 1) ? 5  : 1;
      localparam int SX  = (g == 0) ? 1 : (g == 1) ? 3  : 7;
      localparam int N   = 12;

      logic          s_in_valid, s_in_ready, s_in_signed, s_out_valid, s_out_ready, s_busy;
      logic [WA-1:0] s_in_a;
      logic [WB-1:0] s_in_b;
      logic [3:0]    s_in_tag, s_out_tag;
      logic [WA+WB-1:0] s_out_p;

      pipelined_array_multiplier #(
         .WIDTH_A(WA), .WIDTH_B(WB), .ROWS_PER_STAGE(RPS), .TAG_W(4)
      ) u_dut (
         .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a),
         .in_b(s_in_b), .in_signed(s_in_signed), .in_tag(s_in_tag), .out_valid(s_out_valid),
         .out_ready(s_out_ready), .out_p(s_out_p), .out_tag(s_out_tag), .busy(s_busy)
      );

      initial begin
         longint oa [N];
         longint ob [N];
         bit     os [N];
         int     idx;
         s_in_valid = 1'b0; s_in_a = 'x; s_in_b = 'x; s_in_signed = 1'b0; s_in_tag = '0;
         s_out_ready = 1'b1;
         wait (sweep_go);
         for (int i = 0; i < N; i++) begin
            oa[i] = longint'($urandom) & ((longint'(1) << WA) - 1);
            ob[i] = longint'($urandom) & ((longint'(1) << WB) - 1);
            os[i] = 1'($urandom_range(0, 1));
         end
         // Force the most-negative corner into the stream.
         oa[3] = longint'(1) << (WA - 1); ob[3] = longint'(1) << (WB - 1); os[3] = 1'b1;
         for (int j = 0; j < N + SX + 2; j++) begin
            @(negedge clk);
            idx = j - SX;
            chk("sw_in_ready", 64'(s_in_ready), 64'd1);
            if (idx >= 0 && idx < N) begin
               chk("sw_vld", 64'(s_out_valid), 64'd1);
               chk("sw_p", 64'(s_out_p), ref_mul(oa[idx], ob[idx], os[idx], WA, WB));
               chk("sw_tag", 64'(s_out_tag), 64'(idx % 16));
            end else begin
               chk("sw_idle", 64'(s_out_valid), 64'd0);
            end
            if (j < N) begin
               s_in_valid = 1'b1; s_in_a = WA'(oa[j]); s_in_b = WB'(ob[j]);
               s_in_signed = os[j]; s_in_tag = 4'(j % 16);
            end else begin
               s_in_valid = 1'b0; s_in_a = 'x; s_in_b = 'x;
            end
         end
         chk("sw_busy", 64'(s_busy), 64'd0);
         sweep_done++;
      end
   end

endmodule
